rom_port_arbiter: RTL

Two-port arbiter and read formatter in front of the single-ported, word-wide instruction ROM (`instr_rom`: 14-bit byte address, registered 32-bit output). It shares the ROM between the instruction-fetch port (F) and a data-load port (D) so that loads from code space (lb/lbu/lh/lhu/lw) and fetches interleave, at up to one ROM access per cycle. It returns data to each requester through a tagged, pipelined path. The D port gets byte-lane extraction with sign or zero extension.

---
 rtl/rom_port_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: shares the word-wide instruction ROM between fetch (F) and load (D) requesters, one grant per cycle, fixed latency 2.
// Define ROM_ARB_RR_EN for two-way round-robin; otherwise D has priority over F with a starvation guard.
module rom_port_arbiter #(
  parameter int ADDR_W     = 14,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [31:0]       f_rdata,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [1:0]        d_size,
  input  logic              d_unsigned,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_rdata
);

  typedef struct packed {
    logic       vld;
    logic       port;   // 1 = D
    logic [1:0] lane;
    logic [1:0] size;
    logic       uns;
    logic       err;
  } tag_t;

  logic              f_win;
  logic              d_mis;
  logic [ADDR_W-1:0] addr_q;
  tag_t              s1;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [31:0]       d_fmt;

`ifdef ROM_ARB_RR_EN
  logic last_d;

  // Priority goes to whichever port was not granted most recently.
  always_comb f_win = f_req && (!d_req || last_d);

  always_ff @(posedge clk) begin
    if (!rst_n)     last_d <= 1'b0;
    else if (f_gnt) last_d <= 1'b0;
    else if (d_gnt) last_d <= 1'b1;
  end
`else
  logic [3:0] stv;

  always_comb f_win = f_req && (!d_req || (stv == 4'(STARVE_MAX)));

  // Counts D grants that F sat through; reaching STARVE_MAX forces an F grant.
  always_ff @(posedge clk) begin
    if (!rst_n)                stv <= 4'd0;
    else if (f_gnt || !f_req)  stv <= 4'd0;
    else if (d_gnt)            stv <= stv + 4'd1;
  end
`endif

  assign f_gnt = rst_n && f_win;
  assign d_gnt = rst_n && d_req && !f_win;

  // Idle cycles keep presenting the last granted address to the ROM.
  assign rom_addr = f_gnt ? f_addr : (d_gnt ? d_addr : addr_q);

  always_ff @(posedge clk) begin
    if (!rst_n)                addr_q <= '0;
    else if (f_gnt || d_gnt)   addr_q <= rom_addr;
  end

  always_comb begin
    case (d_size)
      2'b00:   d_mis = 1'b0;
      2'b01:   d_mis = d_addr[0];
      2'b10:   d_mis = |d_addr[1:0];
      default: d_mis = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= '0;
    end else begin
      s1 <= '{vld:  f_gnt | d_gnt,
              port: d_gnt,
              lane: d_addr[1:0],
              size: d_size,
              uns:  d_unsigned,
              err:  d_gnt & d_mis};
    end
  end

  always_comb begin
    case (s1.lane)
      2'd0:    byte_sel = rom_rdata[7:0];
      2'd1:    byte_sel = rom_rdata[15:8];
      2'd2:    byte_sel = rom_rdata[23:16];
      default: byte_sel = rom_rdata[31:24];
    endcase
    half_sel = s1.lane[1] ? rom_rdata[31:16] : rom_rdata[15:0];
    d_fmt    = '0;
    if (!s1.err) begin
      case (s1.size)
        2'b00:   d_fmt = {{24{~s1.uns & byte_sel[7]}}, byte_sel};
        2'b01:   d_fmt = {{16{~s1.uns & half_sel[15]}}, half_sel};
        default: d_fmt = rom_rdata;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      f_rvalid <= 1'b0;
      f_rdata  <= '0;
      d_rvalid <= 1'b0;
      d_rdata  <= '0;
      d_err    <= 1'b0;
    end else begin
      f_rvalid <= s1.vld && !s1.port;
      f_rdata  <= (s1.vld && !s1.port) ? rom_rdata : '0;
      d_rvalid <= s1.vld && s1.port;
      d_rdata  <= (s1.vld && s1.port) ? d_fmt : '0;
      d_err    <= s1.vld && s1.port && s1.err;
    end
  end

endmodule
